// File: rtl/insn_decode_stage.sv
// RV32I decode stage: decodes one fetched instruction per cycle and buffers
// the decoded payload in a small FIFO with valid/ready handshakes on both sides.
module insn_decode_stage #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_en,
  output logic                          fetch_ready,
  input  logic [ADDR_WIDTH-3:0]         fetch_pc,
  input  logic [31:0]                   insn,
  input  logic                          flush,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic [ADDR_WIDTH-1:0]         dec_pc,
  output logic [3:0]                    dec_class,
  output logic [4:0]                    dec_rd,
  output logic [4:0]                    dec_rs1,
  output logic [4:0]                    dec_rs2,
  output logic [2:0]                    dec_funct3,
  output logic                          dec_funct7b5,
  output logic [31:0]                   dec_imm,
  output logic                          dec_wb_en,
  output logic                          dec_illegal,
  output logic [$clog2(QUEUE_DEPTH):0]  occupancy
);

  localparam int unsigned CNT_WIDTH = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned PTR_WIDTH = $clog2(QUEUE_DEPTH);

  localparam logic [3:0] CLS_ALU_R  = 4'd0;
  localparam logic [3:0] CLS_ALU_I  = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;
  localparam logic [3:0] CLS_SYSTEM = 4'd9;
  localparam logic [3:0] CLS_FENCE  = 4'd10;
  localparam logic [3:0] CLS_ILL    = 4'd15;

  typedef struct packed {
    logic [ADDR_WIDTH-3:0] pc;
    logic [3:0]            cls;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic [31:0]           imm;
    logic                  wb_en;
    logic                  illegal;
  } dec_entry_t;

  dec_entry_t               dec_c;
  dec_entry_t               head_c;
  dec_entry_t               mem_q [QUEUE_DEPTH];
  logic [PTR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]     occ_q, occ_d;
  logic                     fetch_ready_q, fetch_ready_d;
  logic                     dec_valid_q, dec_valid_d;
  logic                     push_c, pop_c;
  logic                     wb_class_c;

  // Instruction decode, ahead of the FIFO write so the head is register-sourced
  always_comb begin
    dec_c          = '0;
    wb_class_c     = 1'b0;
    dec_c.pc       = fetch_pc;
    dec_c.rs1      = insn[19:15];
    dec_c.rs2      = insn[24:20];
    dec_c.funct3   = insn[14:12];
    dec_c.funct7b5 = insn[30];
    case (insn[6:0])
      7'b0110011: dec_c.cls = CLS_ALU_R;
      7'b0010011: dec_c.cls = CLS_ALU_I;
      7'b0000011: dec_c.cls = CLS_LOAD;
      7'b0100011: dec_c.cls = CLS_STORE;
      7'b1100011: dec_c.cls = CLS_BRANCH;
      7'b1101111: dec_c.cls = CLS_JAL;
      7'b1100111: dec_c.cls = CLS_JALR;
      7'b0110111: dec_c.cls = CLS_LUI;
      7'b0010111: dec_c.cls = CLS_AUIPC;
      7'b1110011: dec_c.cls = CLS_SYSTEM;
      7'b0001111: dec_c.cls = CLS_FENCE;
      default:    dec_c.cls = CLS_ILL;
    endcase
    case (dec_c.cls)
      CLS_ALU_I, CLS_LOAD, CLS_JALR, CLS_SYSTEM, CLS_FENCE:
        dec_c.imm = {{20{insn[31]}}, insn[31:20]};
      CLS_STORE:
        dec_c.imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      CLS_BRANCH:
        dec_c.imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      CLS_LUI, CLS_AUIPC:
        dec_c.imm = {insn[31:12], 12'h000};
      CLS_JAL:
        dec_c.imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default:
        dec_c.imm = 32'h0000_0000;
    endcase
    case (dec_c.cls)
      CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC:
        wb_class_c = 1'b1;
      default:
        wb_class_c = 1'b0;
    endcase
    dec_c.wb_en   = wb_class_c && (insn[11:7] != 5'd0);
    dec_c.rd      = dec_c.wb_en ? insn[11:7] : 5'd0;
    dec_c.illegal = (dec_c.cls == CLS_ILL);
  end

  // FIFO control; flush overrides both push and pop
  always_comb begin
    push_c        = fetch_en && fetch_ready_q && !flush;
    pop_c         = dec_valid_q && dec_ready && !flush;
    wr_ptr_d      = wr_ptr_q + PTR_WIDTH'(push_c);
    rd_ptr_d      = rd_ptr_q + PTR_WIDTH'(pop_c);
    occ_d         = occ_q + CNT_WIDTH'(push_c) - CNT_WIDTH'(pop_c);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
    fetch_ready_d = (occ_d < CNT_WIDTH'(QUEUE_DEPTH));
    dec_valid_d   = (occ_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      fetch_ready_q <= 1'b1;
      dec_valid_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      fetch_ready_q <= fetch_ready_d;
      dec_valid_q   <= dec_valid_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted as valid
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= dec_c;
    end
  end

  assign head_c       = dec_valid_q ? mem_q[rd_ptr_q] : '0;
  assign fetch_ready  = fetch_ready_q;
  assign dec_valid    = dec_valid_q;
  assign occupancy    = occ_q;
  assign dec_pc       = {head_c.pc, 2'b00};
  assign dec_class    = head_c.cls;
  assign dec_rd       = head_c.rd;
  assign dec_rs1      = head_c.rs1;
  assign dec_rs2      = head_c.rs2;
  assign dec_funct3   = head_c.funct3;
  assign dec_funct7b5 = head_c.funct7b5;
  assign dec_imm      = head_c.imm;
  assign dec_wb_en    = head_c.wb_en;
  assign dec_illegal  = head_c.illegal;

endmodule

// File: tb/tb_insn_decode_stage.sv
// Scoreboard bench for insn_decode_stage: directed decode/handshake cases
// followed by randomised traffic with occasional flushes.
module tb_insn_decode_stage;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
    logic        wb;
    logic        ill;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en;
  logic          fetch_ready;
  logic [AW-3:0] fetch_pc;
  logic [31:0]   insn;
  logic          flush;
  logic          dec_valid;
  logic          dec_ready;
  logic [AW-1:0] dec_pc;
  logic [3:0]    dec_class;
  logic [4:0]    dec_rd, dec_rs1, dec_rs2;
  logic [2:0]    dec_funct3;
  logic          dec_funct7b5;
  logic [31:0]   dec_imm;
  logic          dec_wb_en;
  logic          dec_illegal;
  logic [1:0]    occupancy;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  insn_decode_stage #(.ADDR_WIDTH(AW), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .insn(insn), .flush(flush), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_class(dec_class), .dec_rd(dec_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_funct3(dec_funct3),
    .dec_funct7b5(dec_funct7b5), .dec_imm(dec_imm), .dec_wb_en(dec_wb_en),
    .dec_illegal(dec_illegal), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [29:0] pc, input logic [31:0] i);
    exp_t e;
    e.pc   = {pc, 2'b00};
    e.rs1  = i[19:15];
    e.rs2  = i[24:20];
    e.f3   = i[14:12];
    e.f7b5 = i[30];
    case (i[6:0])
      7'h33: e.cls = 4'd0;
      7'h13: e.cls = 4'd1;
      7'h03: e.cls = 4'd2;
      7'h23: e.cls = 4'd3;
      7'h63: e.cls = 4'd4;
      7'h6F: e.cls = 4'd5;
      7'h67: e.cls = 4'd6;
      7'h37: e.cls = 4'd7;
      7'h17: e.cls = 4'd8;
      7'h73: e.cls = 4'd9;
      7'h0F: e.cls = 4'd10;
      default: e.cls = 4'd15;
    endcase
    case (e.cls)
      4'd1, 4'd2, 4'd6, 4'd9, 4'd10: e.imm = 32'($signed(i[31:20]));
      4'd3: e.imm = 32'($signed({i[31:25], i[11:7]}));
      4'd4: e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      4'd5: e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      4'd7, 4'd8: e.imm = {i[31:12], 12'h000};
      default: e.imm = 32'h0;
    endcase
    e.wb  = (e.cls inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8}) && (i[11:7] != 5'd0);
    e.rd  = e.wb ? i[11:7] : 5'd0;
    e.ill = (e.cls == 4'd15);
    return e;
  endfunction

  // One clock: check outputs at negedge against the scoreboard, then advance
  task automatic cycle();
    exp_t e;
    logic rdy_m;
    @(negedge clk);
    chk("occupancy", 32'(occupancy), 32'(sb.size()));
    chk("fetch_ready", 32'(fetch_ready), 32'(sb.size() < DEPTH));
    chk("dec_valid", 32'(dec_valid), 32'(sb.size() != 0));
    if (!dec_valid)
      chk("idle_payload", 32'(|{dec_pc, dec_class, dec_rd, dec_rs1, dec_rs2, dec_funct3,
                                dec_funct7b5, dec_imm, dec_wb_en, dec_illegal}), 32'h0);
    rdy_m = (sb.size() < DEPTH);
    if (flush) begin
      sb.delete();
    end else begin
      if (dec_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("pc", dec_pc, e.pc);
        chk("class", 32'(dec_class), 32'(e.cls));
        chk("rd", 32'(dec_rd), 32'(e.rd));
        chk("rs1", 32'(dec_rs1), 32'(e.rs1));
        chk("rs2", 32'(dec_rs2), 32'(e.rs2));
        chk("funct3", 32'(dec_funct3), 32'(e.f3));
        chk("funct7b5", 32'(dec_funct7b5), 32'(e.f7b5));
        chk("imm", dec_imm, e.imm);
        chk("wb_en", 32'(dec_wb_en), 32'(e.wb));
        chk("illegal", 32'(dec_illegal), 32'(e.ill));
      end
      if (fetch_en && rdy_m) sb.push_back(model(fetch_pc, insn));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  logic [31:0] ops [12] = '{32'h33, 32'h13, 32'h03, 32'h23, 32'h63, 32'h6F,
                            32'h67, 32'h37, 32'h17, 32'h73, 32'h0F, 32'h00};

  initial begin
    logic [31:0] r, op;
    rst = 1'b1; fetch_en = 1'b0; fetch_pc = '0; insn = '0; flush = 1'b0; dec_ready = 1'b0;
    do_reset();
    chk("rst_occupancy", 32'(occupancy), 32'h0);
    chk("rst_dec_valid", 32'(dec_valid), 32'h0);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'h1);

    // addi x1,x0,5 at PC 0x100
    dec_ready = 1'b1; fetch_en = 1'b1; fetch_pc = 30'(32'h100 >> 2); insn = 32'h00500093;
    cycle();
    fetch_en = 1'b0;
    chk("t1_valid", 32'(dec_valid), 32'h1);
    chk("t1_pc", dec_pc, 32'h100);
    chk("t1_class", 32'(dec_class), 32'd1);
    chk("t1_rd", 32'(dec_rd), 32'd1);
    chk("t1_imm", dec_imm, 32'd5);
    chk("t1_wb", 32'(dec_wb_en), 32'h1);
    cycle();
    cycle();

    // sw, jal, all-zero (illegal) back to back
    fetch_en = 1'b1; fetch_pc = 30'h50; insn = 32'hFE20AE23;
    cycle();
    chk("sw_class", 32'(dec_class), 32'd3);
    chk("sw_imm", dec_imm, 32'hFFFF_FFFC);
    chk("sw_rd", 32'(dec_rd), 32'd0);
    fetch_pc = 30'h51; insn = 32'hFF9FF0EF;
    cycle();
    chk("jal_class", 32'(dec_class), 32'd5);
    chk("jal_imm", dec_imm, 32'hFFFF_FFF8);
    chk("jal_wb", 32'(dec_wb_en), 32'h1);
    fetch_pc = 30'h52; insn = 32'h0;
    cycle();
    chk("ill_class", 32'(dec_class), 32'd15);
    chk("ill_flag", 32'(dec_illegal), 32'h1);
    fetch_en = 1'b0;
    cycle();
    cycle();

    // Backpressure: fill, hold a third, then drain in order
    dec_ready = 1'b0; fetch_en = 1'b1;
    fetch_pc = 30'h200; insn = 32'h002081B3; cycle();
    fetch_pc = 30'h201; insn = 32'h12345237; cycle();
    fetch_pc = 30'h202; insn = 32'h00C0006F; cycle();
    chk("full_occupancy", 32'(occupancy), 32'd2);
    chk("full_fetch_ready", 32'(fetch_ready), 32'h0);
    dec_ready = 1'b1;
    cycle();
    cycle();
    fetch_en = 1'b0;
    cycle();
    cycle();

    // Flush with a simultaneous push and pop
    dec_ready = 1'b0; fetch_en = 1'b1;
    fetch_pc = 30'h300; insn = 32'h00100113; cycle();
    fetch_pc = 30'h301; insn = 32'h00200193; cycle();
    flush = 1'b1; dec_ready = 1'b1; fetch_pc = 30'h302; insn = 32'h00300213;
    cycle();
    flush = 1'b0; fetch_en = 1'b0;
    chk("flush_occupancy", 32'(occupancy), 32'h0);
    chk("flush_dec_valid", 32'(dec_valid), 32'h0);
    chk("flush_fetch_ready", 32'(fetch_ready), 32'h1);
    cycle();
    cycle();

    // Reset in mid-operation drops contents
    dec_ready = 1'b0; fetch_en = 1'b1;
    fetch_pc = 30'h400; insn = 32'h00500093; cycle();
    fetch_en = 1'b0;
    do_reset();
    chk("midrst_dec_valid", 32'(dec_valid), 32'h0);
    cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      op = ops[$urandom_range(0, 11)];
      fetch_en  = ($urandom_range(0, 3) != 0);
      dec_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      fetch_pc  = 30'($urandom());
      insn      = (op == 32'h0) ? r : {r[31:7], op[6:0]};
      cycle();
    end
    fetch_en = 1'b0; flush = 1'b0; dec_ready = 1'b1;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/insn_decode_stage.md
Name: insn_decode_stage

Overview:
Parametrised RV32I decode stage for the mig-u core, placed between instruction fetch and issue.
- Each cycle it accepts one fetched instruction and its word-aligned PC, and fully decodes it: opcode class, register indices, funct fields, sign-extended immediate, illegal flag.
- Decoded results are buffered in a QUEUE_DEPTH-entry FIFO with valid/ready handshakes on both sides.
- A flush input discards all buffered instructions on redirect.

Parameters:
- ADDR_WIDTH, 32, PC width in bits; PC bits [1:0] are implicit zero.
- QUEUE_DEPTH, 2, decoded-instruction FIFO entries; power of two, >= 2.
- CNT_WIDTH, $clog2(QUEUE_DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_en  in  1  fetch presents a valid instruction
- fetch_ready  out  1  stage can accept this cycle
- fetch_pc  in  ADDR_WIDTH-2  PC bits [ADDR_WIDTH-1:2]
- insn  in  32  raw instruction
- flush  in  1  discard all buffered and incoming instructions
- dec_valid  out  1  FIFO head holds a decoded instruction
- dec_ready  in  1  issue consumes the head
- dec_pc  out  ADDR_WIDTH  full byte PC of head, {fetch_pc,2'b00}
- dec_class  out  4  opcode class (encoding below)
- dec_rd  out  5  destination register; 0 when dec_wb_en=0
- dec_rs1  out  5  insn[19:15]
- dec_rs2  out  5  insn[24:20]
- dec_funct3  out  3  insn[14:12]
- dec_funct7b5  out  1  insn[30]
- dec_imm  out  32  sign-extended immediate
- dec_wb_en  out  1  writes rd, and rd != 0
- dec_illegal  out  1  illegal encoding
- occupancy  out  CNT_WIDTH  entries currently held

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO empty, occupancy=0, dec_valid=0.
  - fetch_ready=1 from the first cycle after reset.
  - All dec_* payload outputs are 0 while empty.
  - Reset mid-operation drops all contents.
- Push and pop:
  - Push when fetch_en && fetch_ready.
  - Pop when dec_valid && dec_ready.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Ready and full rules:
  - fetch_ready = (occupancy < QUEUE_DEPTH). It is registered-state only; there is no combinational path from dec_ready.
  - When full, fetch_ready=0 even if a pop occurs that cycle.
- Latency: an instruction pushed at edge N appears at the head (dec_valid=1) after edge N if the FIFO was empty. Otherwise it waits behind older entries, in order.
- Decode:
  - Combinational on insn, done before the FIFO write, so FIFO outputs come directly from registers.
  - dec_class by insn[6:0]:
    - 0110011 -> 0 ALU_R
    - 0010011 -> 1 ALU_I
    - 0000011 -> 2 LOAD
    - 0100011 -> 3 STORE
    - 1100011 -> 4 BRANCH
    - 1101111 -> 5 JAL
    - 1100111 -> 6 JALR
    - 0110111 -> 7 LUI
    - 0010111 -> 8 AUIPC
    - 1110011 -> 9 SYSTEM
    - 0001111 -> 10 FENCE
    - anything else -> 15 ILLEGAL
  - dec_illegal=1 iff class==15, or insn[1:0]!=2'b11 (which forces class 15).
  - Illegal instructions are still queued and delivered, so the core can trap.
- Immediate (dec_imm) by class:
  - I-type (ALU_I, LOAD, JALR, SYSTEM, FENCE): sext(insn[31:20]).
  - S-type (STORE): sext({insn[31:25],insn[11:7]}).
  - B-type (BRANCH): sext({insn[31],insn[7],insn[30:25],insn[11:8],1'b0}).
  - U-type (LUI, AUIPC): {insn[31:12],12'b0}.
  - J-type (JAL): sext({insn[31],insn[19:12],insn[20],insn[30:21],1'b0}).
  - ALU_R and ILLEGAL: 0.
- Writeback enable: dec_wb_en=1 for ALU_R, ALU_I, LOAD, JAL, JALR, LUI, AUIPC when insn[11:7]!=0; otherwise dec_wb_en=0 and dec_rd=0.
- Flush:
  - At the edge with flush=1, the FIFO empties (occupancy=0, dec_valid=0 the next cycle).
  - Flush has priority over a simultaneous push, which is discarded, and over a simultaneous pop.
- Pointers: read and write pointers wrap modulo QUEUE_DEPTH.
  - Full: occupancy==QUEUE_DEPTH.
  - Empty: occupancy==0.
- Payload on empty: dec_* payload outputs are forced to 0 whenever dec_valid=0.

Test Plan:
- Reset, then push insn=0x00500093 at fetch_pc=0x100>>2 (PC 0x100), dec_ready=1 -> next cycle dec_valid=1, dec_pc=0x100, class=1, rd=1, rs1=0, imm=5, wb_en=1, illegal=0; popped the following cycle.
- Push 0xFE20AE23 (sw x2,-4(x1)) -> class=3, rs1=1, rs2=2, funct3=2, imm=0xFFFFFFFC, wb_en=0, rd=0.
- Push 0xFF9FF0EF (jal x1,-8) -> class=5, rd=1, imm=0xFFFFFFF8, wb_en=1.
- Push 0x00000000 -> class=15, illegal=1, imm=0, wb_en=0; still delivered in order.
- QUEUE_DEPTH=2, dec_ready=0, fetch_en=1 with three distinct PCs -> fetch_ready=0 after two pushes, occupancy=2, third held. Raise dec_ready -> outputs appear in push order, nothing lost or duplicated.
- FIFO holding 2, assert flush with fetch_en=1 and dec_ready=1 in the same cycle -> next cycle occupancy=0, dec_valid=0, fetch_ready=1; the incoming instruction never appears.
